// File: rtl/frame_buffer_reader_pkg.sv
// Shared frame-buffer geometry, pixel format and the luma helper used by the
// frame buffer read path.
package frame_buf_pkg;

  localparam int H_PIXELS   = 160;
  localparam int V_PIXELS   = 120;
  localparam int FRAME_SIZE = H_PIXELS * V_PIXELS;
  localparam int ADDR_W     = $clog2(FRAME_SIZE);

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Returns Y8[7:4], where Y8 = (R8*77 + G8*150 + B8*29) >> 8 on channels widened to 8 bits.
  function automatic logic [3:0] gray_y4(input rgb565_t p);
    logic [15:0] acc;
    acc = 16'({p.r, 3'b000}) * 16'd77
        + 16'({p.g, 2'b00}) * 16'd150
        + 16'({p.b, 3'b000}) * 16'd29;
    return 4'(acc >> 12);
  endfunction

endpackage

// File: rtl/frame_buffer_reader_if.sv
// Frame buffer read port: address and bank select out, RGB565 data back.
interface frame_buffer_reader_if #(
  parameter int ADDR_W = frame_buf_pkg::ADDR_W
);
  logic [ADDR_W-1:0] rAddr;
  logic              rd_buf;
  logic [15:0]       rData;

  modport master (output rAddr, output rd_buf, input rData);
  modport slave  (input rAddr, input rd_buf, output rData);
endinterface

// File: rtl/frame_buffer_reader_sync_delay_line.sv
// Fixed-depth shift register that keeps display control bits aligned with
// the pixel data coming back from the frame buffer.
module sync_delay_line #(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/frame_buffer_reader.sv
// Upscaling frame buffer reader: display coordinates -> buffer address -> RGB444.
// Define GRAYSCALE_EN to add the gray_en input and one extra luma pipeline stage.
module frame_buffer_reader #(
  parameter int H_PIXELS   = frame_buf_pkg::H_PIXELS,
  parameter int V_PIXELS   = frame_buf_pkg::V_PIXELS,
  parameter int SCALE      = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x_pixel,
  input  logic [9:0] y_pixel,
  input  logic       de_in,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  input  logic       wr_buf_sel,
`ifdef GRAYSCALE_EN
  input  logic       gray_en,
`endif
  frame_buffer_reader_if.master mem,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       de_out,
  output logic       h_sync_out,
  output logic       v_sync_out
);
  import frame_buf_pkg::*;

  localparam int AW    = $clog2(H_PIXELS * V_PIXELS);
  localparam int SHIFT = $clog2(SCALE);
`ifdef GRAYSCALE_EN
  localparam int L = 3 + RD_LATENCY;
`else
  localparam int L = 2 + RD_LATENCY;
`endif
  localparam logic [10:0] X_LIM    = 11'(H_PIXELS * SCALE);
  localparam logic [10:0] Y_LIM    = 11'(V_PIXELS * SCALE);
  localparam logic [3:0]  SYNC_RST = 4'b0011;

  logic          in_img, in_img_d, frame_start;
  logic [AW-1:0] addr_next;
  logic [3:0]    r_q, g_q, b_q;

  assign in_img      = de_in && ({1'b0, x_pixel} < X_LIM) && ({1'b0, y_pixel} < Y_LIM);
  assign frame_start = de_in && (x_pixel == 10'd0) && (y_pixel == 10'd0);
  assign addr_next   = AW'(y_pixel >> SHIFT) * AW'(H_PIXELS) + AW'(x_pixel >> SHIFT);

  // Bank is latched from the live wr_buf_sel so a swap on the frame-start cycle is honoured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem.rAddr  <= '0;
      mem.rd_buf <= 1'b0;
    end else begin
      if (in_img)      mem.rAddr  <= addr_next;
      if (frame_start) mem.rd_buf <= ~wr_buf_sel;
    end
  end

`ifdef GRAYSCALE_EN
  rgb565_t pix_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_q <= '0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else begin
      pix_q <= mem.rData;
      if (gray_en) begin
        r_q <= gray_y4(pix_q);
        g_q <= gray_y4(pix_q);
        b_q <= gray_y4(pix_q);
      end else begin
        r_q <= pix_q.r[4:1];
        g_q <= pix_q.g[5:2];
        b_q <= pix_q.b[4:1];
      end
    end
  end
`else
  logic unused_rdata_bits;
  assign unused_rdata_bits = ^{mem.rData[11], mem.rData[6:5], mem.rData[0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      r_q <= mem.rData[15:12];
      g_q <= mem.rData[10:7];
      b_q <= mem.rData[4:1];
    end
  end
`endif

  sync_delay_line #(
    .WIDTH     (4),
    .DEPTH     (L),
    .RESET_VAL (SYNC_RST)
  ) u_sync_delay (
    .clk   (clk),
    .reset (reset),
    .din   ({in_img, de_in, h_sync_in, v_sync_in}),
    .dout  ({in_img_d, de_out, h_sync_out, v_sync_out})
  );

  // Pixels outside the image (or in blanking) leave the colour registers running but show black.
  assign red   = in_img_d ? r_q : 4'h0;
  assign green = in_img_d ? g_q : 4'h0;
  assign blue  = in_img_d ? b_q : 4'h0;

endmodule
